// File: rtl/div_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEF = 8;
    localparam int CNT_W = $clog2(W_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_prem,
    input  logic         i_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_prem,
    output logic         o_qbit
);

    logic [W:0] w_t;

    assign w_t    = {i_prem, i_bit};
    assign o_qbit = (w_t >= {1'b0, i_divisor});
    // The difference is below the divisor, so W-bit wraparound arithmetic is exact.
    assign o_prem = o_qbit ? (w_t[W-1:0] - i_divisor) : w_t[W-1:0];

endmodule

// File: rtl/approx_div_seq.sv
// Sequential 2W/W restoring divider, one quotient bit per cycle.
// Define DIV_APPROX_EN to skip the TRUNC quotient LSBs and drop the remainder.
module approx_div_seq
    import div_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int TRUNC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

`ifdef DIV_APPROX_EN
    localparam int TRUNC_EFF = TRUNC;
`else
    localparam int TRUNC_EFF = 0 * TRUNC;
`endif
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int ITER = W - TRUNC_EFF;
    localparam logic [CW-1:0] CNT_INIT = CW'(ITER - 1);

    state_t        r_state;
    logic [W-1:0]  r_prem;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_div;
    logic [W-1:0]  r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_dz;
    logic          r_ovf;

    logic [W-1:0]  w_prem;
    logic          w_qbit;
    logic [W-1:0]  w_qnext;

    div_step #(.W(W)) u_step (
        .i_prem    (r_prem),
        .i_bit     (r_lo[W-1]),
        .i_divisor (r_div),
        .o_prem    (w_prem),
        .o_qbit    (w_qbit)
    );

    assign w_qnext = {r_quot[W-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prem  <= '0;
            r_lo    <= '0;
            r_div   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_div <= divisor;
                        r_dz  <= 1'b0;
                        r_ovf <= 1'b0;
                        if (divisor == '0) begin
                            r_dz    <= 1'b1;
                            r_quot  <= '1;
                            r_prem  <= dividend[W-1:0];
                            r_state <= DONE;
                        end else if (dividend[2*W-1:W] >= divisor) begin
                            r_ovf   <= 1'b1;
                            r_quot  <= '1;
                            r_prem  <= '0;
                            r_state <= DONE;
                        end else begin
                            r_prem  <= dividend[2*W-1:W];
                            r_lo    <= dividend[W-1:0];
                            r_quot  <= '0;
                            r_cnt   <= CNT_INIT;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_prem <= w_prem;
                    r_lo   <= {r_lo[W-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        // Realign a shortened quotient so skipped LSBs read as 0.
                        r_quot  <= w_qnext << TRUNC_EFF;
                        r_state <= DONE;
                    end else begin
                        r_quot <= w_qnext;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quot;
    assign div_zero  = r_dz;
    assign ovf       = r_ovf;

`ifdef DIV_APPROX_EN
    assign remainder = (r_dz | r_ovf) ? r_prem : '0;
`else
    assign remainder = r_prem;
`endif

endmodule

// File: tb/tb_approx_div_seq.sv
// Self-checking bench for approx_div_seq (W=8, TRUNC=2), vector table plus scoreboard.
module tb_approx_div_seq;

    localparam int W = 8;
    localparam int TRUNC = 2;
`ifdef DIV_APPROX_EN
    localparam int NLAT = W - TRUNC + 1;
`else
    localparam int NLAT = W + 1;
`endif

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    int n_chk = 0;
    int n_fail = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    approx_div_seq #(.W(W), .TRUNC(TRUNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t adj(input vec_t v);
        vec_t o = v;
`ifdef DIV_APPROX_EN
        if (!v.dz && !v.ovf) begin
            o.q = v.q & ~8'((1 << TRUNC) - 1);
            o.r = '0;
        end
`endif
        return o;
    endfunction

    function automatic vec_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        vec_t v;
        logic [15:0] qq;
        logic [15:0] rr;
        v.dvd = dvd;
        v.dvs = dvs;
        v.dz  = 1'b0;
        v.ovf = 1'b0;
        if (dvs == 8'd0) begin
            v.dz = 1'b1;
            v.q  = 8'hFF;
            v.r  = dvd[7:0];
        end else if (dvd[15:8] >= dvs) begin
            v.ovf = 1'b1;
            v.q   = 8'hFF;
            v.r   = 8'h00;
        end else begin
            qq  = dvd / {8'd0, dvs};
            rr  = dvd % {8'd0, dvs};
            v.q = qq[7:0];
            v.r = rr[7:0];
        end
        return adj(v);
    endfunction

    task automatic send(input logic [15:0] dvd, input logic [7:0] dvs);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic collect(input int hold);
        vec_t e;
        int lat;
        int exp_lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got output, expected none");
        end else begin
            e = sb.pop_front();
            exp_lat = (e.dz || e.ovf) ? 1 : NLAT;
            chk("latency", lat, exp_lat);
            for (int h = 0; h <= hold; h++) begin
                chk("out_valid", {31'd0, out_valid}, 32'd1);
                chk("in_ready_done", {31'd0, in_ready}, 32'd0);
                chk("quotient", {24'd0, quotient}, {24'd0, e.q});
                chk("remainder", {24'd0, remainder}, {24'd0, e.r});
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                if (h < hold) begin
                    in_valid = 1'b1;
                    dividend = 16'($urandom);
                    divisor  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        vec_t tbl[11];
        vec_t v;
        int idle;

        tbl[0]  = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0};
        tbl[1]  = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{16'h0800, 8'h08, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[3]  = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0};
        tbl[4]  = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[8]  = '{16'h0001, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0};
        tbl[9]  = '{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0};
        tbl[10] = '{16'h0000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {24'd0, quotient}, 32'd0);
        chk("rst_remainder", {24'd0, remainder}, 32'd0);
        chk("rst_flags", {30'd0, div_zero, ovf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            sb.push_back(adj(tbl[i]));
            send(tbl[i].dvd, tbl[i].dvs);
            collect((i == 0) ? 5 : 0);
        end

        for (int i = 0; i < 20; i++) begin
            v = model(16'($urandom), 8'($urandom_range(1, 255)));
            sb.push_back(v);
            send(v.dvd, v.dvs);
            collect(0);
        end

        sb.push_back(adj(tbl[0]));
        send(16'h03E8, 8'h07);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrun_rst_quotient", {24'd0, quotient}, 32'd0);
        chk("midrun_rst_remainder", {24'd0, remainder}, 32'd0);
        chk("midrun_rst_flags", {30'd0, div_zero, ovf}, 32'd0);
        idle = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) idle++;
        end
        chk("no_pulse_after_rst", idle, 0);

        sb.push_back(adj(tbl[4]));
        send(16'h0064, 8'h0A);
        collect(0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
